pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage.sv | 123 ++++++++++++
 tb/tb_pc_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a short
// post-reset boot delay. Redirects take priority over stalls.
module pc_fetch_stage #(
    parameter int unsigned       PC_W      = 64,
    parameter logic [PC_W-1:0]   RESET_VEC = '0,
    parameter int unsigned       BOOT_CYC  = 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            stall,
    input  logic            br_taken,
    input  logic            uncond_br,
    input  logic            br_reg,
    input  logic [PC_W-1:0] reg_target,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic            if_valid,
    output logic            redirect
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e          r_state, w_state_d;
    logic [3:0]      r_boot_cnt, w_boot_cnt_d;
    logic [PC_W-1:0] r_pc, w_pc_d;
    logic [PC_W-1:0] r_if_pc, w_if_pc_d;
    logic [31:0]     r_if_instr, w_if_instr_d;
    logic            r_if_valid, w_if_valid_d;
    logic            r_redirect, w_redirect_d;

    // Word offsets sign-extended to 64 bits, then truncated to PC_W so that
    // the addition wraps modulo 2^PC_W.
    logic [63:0]     w_cond_ext;
    logic [63:0]     w_unc_ext;
    logic [PC_W-1:0] w_cond_off;
    logic [PC_W-1:0] w_unc_off;
    logic [PC_W-1:0] w_reg_tgt;
    logic [PC_W-1:0] w_target;
    logic            w_take;

    assign w_cond_ext = {{43{r_if_instr[23]}}, r_if_instr[23:5], 2'b00};
    assign w_unc_ext  = {{36{r_if_instr[25]}}, r_if_instr[25:0], 2'b00};
    assign w_cond_off = PC_W'(w_cond_ext);
    assign w_unc_off  = PC_W'(w_unc_ext);
    assign w_reg_tgt  = reg_target & ~(PC_W'(3));

    // Target select: register target overrides the unconditional offset.
    always_comb begin
        w_target = r_if_pc + w_cond_off;
        if (br_reg) begin
            w_target = w_reg_tgt;
        end else if (uncond_br) begin
            w_target = r_if_pc + w_unc_off;
        end
    end

    // A branch only counts when it refers to a live IF/ID instruction.
    assign w_take = (r_state == StRun) && br_taken && r_if_valid;

    // Next-state logic: boot countdown, then redirect > stall > sequential.
    always_comb begin
        w_state_d     = r_state;
        w_boot_cnt_d  = r_boot_cnt;
        w_pc_d        = r_pc;
        w_if_pc_d     = r_if_pc;
        w_if_instr_d  = r_if_instr;
        w_if_valid_d  = r_if_valid;
        w_redirect_d  = 1'b0;
        case (r_state)
            StBoot: begin
                if (r_boot_cnt <= 4'd1) begin
                    w_boot_cnt_d = '0;
                    w_state_d    = StRun;
                end else begin
                    w_boot_cnt_d = r_boot_cnt - 4'd1;
                end
            end
            StRun: begin
                if (w_take) begin
                    w_pc_d       = w_target;
                    w_if_valid_d = 1'b0;
                    w_redirect_d = 1'b1;
                end else if (!stall) begin
                    w_pc_d       = r_pc + PC_W'(4);
                    w_if_instr_d = imem_data;
                    w_if_pc_d    = r_pc;
                    w_if_valid_d = 1'b1;
                end
            end
            default: w_state_d = StBoot;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StBoot;
            r_boot_cnt <= 4'(BOOT_CYC);
            r_pc       <= RESET_VEC;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_if_valid <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_boot_cnt <= w_boot_cnt_d;
            r_pc       <= w_pc_d;
            r_if_pc    <= w_if_pc_d;
            r_if_instr <= w_if_instr_d;
            r_if_valid <= w_if_valid_d;
            r_redirect <= w_redirect_d;
        end
    end

    assign imem_addr = r_pc;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign if_valid  = r_if_valid;
    assign redirect  = r_redirect;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: a 64-bit instance driven from a vector table
// through an expectation queue, plus a 16-bit instance for wrap-around.
module tb_pc_fetch_stage;

    localparam logic [31:0] CondI = 32'h540000A0; // imm19 = 5
    localparam logic [31:0] UncI  = 32'h17FFFFFD; // imm26 = -3
    localparam logic [31:0] BackI = 32'h54FFFFC0; // imm19 = -2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    // 64-bit instance
    logic [63:0] imem_addr, reg_target, if_pc;
    logic [31:0] imem_data, if_instr, r_i200;
    logic        stall, br_taken, uncond_br, br_reg, if_valid, redirect;

    assign imem_data = (imem_addr == 64'h200) ? r_i200 : 32'h1000_0000 + imem_addr[31:0];

    pc_fetch_stage #(.PC_W(64), .RESET_VEC(64'h100), .BOOT_CYC(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .stall      (stall),
        .br_taken   (br_taken),
        .uncond_br  (uncond_br),
        .br_reg     (br_reg),
        .reg_target (reg_target),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .redirect   (redirect)
    );

    // 16-bit instance
    logic [15:0] s_addr, s_tgt, s_if_pc;
    logic [31:0] s_data, s_if_instr;
    logic        s_br, s_if_valid, s_redirect;

    assign s_data = (s_addr == 16'h0004) ? BackI : {16'hA000, s_addr};

    pc_fetch_stage #(.PC_W(16), .RESET_VEC(16'hFFF0), .BOOT_CYC(1)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (s_addr),
        .imem_data  (s_data),
        .stall      (1'b0),
        .br_taken   (s_br),
        .uncond_br  (1'b0),
        .br_reg     (1'b0),
        .reg_target (s_tgt),
        .if_instr   (s_if_instr),
        .if_pc      (s_if_pc),
        .if_valid   (s_if_valid),
        .redirect   (s_redirect)
    );

    typedef struct {
        logic        st, br, un, rg;
        logic [63:0] tgt;
        logic [31:0] i200;
        logic [63:0] addr;
        logic        ifv;
        logic [63:0] ifpc;
        logic [31:0] instr;
        logic        chk_pc;
        logic        red;
    } vec_t;

    vec_t tbl[22];
    vec_t sb[$];

    function automatic vec_t mk(logic st, logic br, logic un, logic rg, logic [63:0] tg,
                                logic [31:0] i2, logic [63:0] ad, logic v, logic [63:0] pc,
                                logic [31:0] ins, logic ck, logic rd);
        vec_t r;
        r.st = st; r.br = br; r.un = un; r.rg = rg; r.tgt = tg; r.i200 = i2;
        r.addr = ad; r.ifv = v; r.ifpc = pc; r.instr = ins; r.chk_pc = ck; r.red = rd;
        return r;
    endfunction

    function automatic logic [31:0] mem_of(input logic [63:0] a);
        return 32'h1000_0000 + a[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t e;
        // Boot (inputs must be ignored), sequential run, stalls, redirects.
        tbl[0]  = mk(1, 1, 0, 1, 64'h500, CondI, 64'h100, 0, 64'h0, 32'h0, 1, 0);
        tbl[1]  = mk(1, 1, 1, 0, 64'h0, CondI, 64'h100, 0, 64'h0, 32'h0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 64'h0, CondI, 64'h104, 1, 64'h100, mem_of(64'h100), 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 64'h0, CondI, 64'h108, 1, 64'h104, mem_of(64'h104), 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 64'h0, CondI, 64'h10C, 1, 64'h108, mem_of(64'h108), 1, 0);
        tbl[5]  = mk(1, 0, 0, 0, 64'h0, CondI, 64'h10C, 1, 64'h108, mem_of(64'h108), 1, 0);
        tbl[6]  = mk(1, 0, 0, 0, 64'h0, CondI, 64'h10C, 1, 64'h108, mem_of(64'h108), 1, 0);
        tbl[7]  = mk(1, 0, 0, 0, 64'h0, CondI, 64'h10C, 1, 64'h108, mem_of(64'h108), 1, 0);
        tbl[8]  = mk(0, 1, 1, 1, 64'h203, CondI, 64'h200, 0, 64'h0, 32'h0, 0, 1);
        tbl[9]  = mk(0, 1, 1, 0, 64'h0, CondI, 64'h204, 1, 64'h200, CondI, 1, 0);
        tbl[10] = mk(0, 1, 0, 0, 64'h0, CondI, 64'h214, 0, 64'h0, 32'h0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 64'h0, CondI, 64'h218, 1, 64'h214, mem_of(64'h214), 1, 0);
        tbl[12] = mk(0, 1, 0, 1, 64'h200, CondI, 64'h200, 0, 64'h0, 32'h0, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 64'h0, UncI, 64'h204, 1, 64'h200, UncI, 1, 0);
        tbl[14] = mk(0, 1, 1, 0, 64'h0, UncI, 64'h1F4, 0, 64'h0, 32'h0, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 64'h0, CondI, 64'h1F8, 1, 64'h1F4, mem_of(64'h1F4), 1, 0);
        tbl[16] = mk(1, 1, 1, 1, 64'hDEADBEEF, CondI, 64'hDEADBEEC, 0, 64'h0, 32'h0, 0, 1);
        tbl[17] = mk(1, 0, 0, 0, 64'h0, CondI, 64'hDEADBEEC, 0, 64'h0, 32'h0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 64'h0, CondI, 64'hDEADBEF0, 1, 64'hDEADBEEC,
                     mem_of(64'hDEADBEEC), 1, 0);
        for (int i = 19; i < 22; i++) begin
            tbl[i] = mk(1, 0, 0, 0, 64'h0, CondI, 64'hDEADBEF0, 1, 64'hDEADBEEC,
                        mem_of(64'hDEADBEEC), 1, 0);
        end

        stall = 0; br_taken = 0; uncond_br = 0; br_reg = 0; reg_target = '0; r_i200 = CondI;
        s_br = 0; s_tgt = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("reset imem_addr", imem_addr, 64'h100);
        chk("reset if_valid", {63'h0, if_valid}, 64'h0);
        chk("reset if_pc", if_pc, 64'h0);
        chk("reset if_instr", {32'h0, if_instr}, 64'h0);
        chk("reset redirect", {63'h0, redirect}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            stall = tbl[i].st; br_taken = tbl[i].br; uncond_br = tbl[i].un;
            br_reg = tbl[i].rg; reg_target = tbl[i].tgt; r_i200 = tbl[i].i200;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("row%0d imem_addr", i), imem_addr, e.addr);
            chk($sformatf("row%0d if_valid", i), {63'h0, if_valid}, {63'h0, e.ifv});
            chk($sformatf("row%0d redirect", i), {63'h0, redirect}, {63'h0, e.red});
            if (e.chk_pc) begin
                chk($sformatf("row%0d if_pc", i), if_pc, e.ifpc);
                chk($sformatf("row%0d if_instr", i), {32'h0, if_instr}, {32'h0, e.instr});
            end
        end

        // Async reset while a redirect pulse is high.
        stall = 0; br_taken = 1; uncond_br = 0; br_reg = 1; reg_target = 64'h300;
        @(posedge clk);
        #1;
        chk("pre-reset redirect", {63'h0, redirect}, 64'h1);
        chk("pre-reset imem_addr", imem_addr, 64'h300);
        #2 reset = 1'b0;
        #1;
        chk("async imem_addr", imem_addr, 64'h100);
        chk("async if_valid", {63'h0, if_valid}, 64'h0);
        chk("async if_pc", if_pc, 64'h0);
        chk("async if_instr", {32'h0, if_instr}, 64'h0);
        chk("async redirect", {63'h0, redirect}, 64'h0);
        chk("async imem_addr16", {48'h0, s_addr}, 64'hFFF0);
        br_taken = 0; br_reg = 0; reg_target = '0;
        @(negedge clk);
        reset = 1'b1;

        // Re-boot of the 64-bit instance and 16-bit wrap-around.
        @(posedge clk); #1;
        chk("reboot e1 if_valid", {63'h0, if_valid}, 64'h0);
        chk("w16 e1 addr", {48'h0, s_addr}, 64'hFFF0);
        @(posedge clk); #1;
        chk("reboot e2 if_valid", {63'h0, if_valid}, 64'h0);
        chk("w16 e2 addr", {48'h0, s_addr}, 64'hFFF4);
        @(posedge clk); #1;
        chk("reboot e3 if_valid", {63'h0, if_valid}, 64'h1);
        chk("reboot e3 if_pc", if_pc, 64'h100);
        @(posedge clk); #1;
        chk("w16 e4 addr", {48'h0, s_addr}, 64'hFFFC);
        @(posedge clk); #1;
        chk("w16 wrap addr", {48'h0, s_addr}, 64'h0000);
        chk("w16 wrap if_pc", {48'h0, s_if_pc}, 64'hFFFC);
        repeat (2) @(posedge clk);
        #1;
        chk("w16 e7 if_pc", {48'h0, s_if_pc}, 64'h0004);
        chk("w16 e7 if_instr", {32'h0, s_if_instr}, {32'h0, BackI});
        s_br = 1'b1;
        @(posedge clk); #1;
        chk("w16 back target", {48'h0, s_addr}, 64'hFFFC);
        chk("w16 redirect", {63'h0, s_redirect}, 64'h1);
        chk("w16 squash", {63'h0, s_if_valid}, 64'h0);
        s_br = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
